// File: rtl/jtag_dbg_pkg.sv
// Shared encodings for the JTAG debug user DR and its bus master.
// Build option: define JTAG_DBG_TIMEOUT_EN to enable the ACK timeout counter.
package jtag_dbg_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   localparam int ST_BUSY    = 0;
   localparam int ST_BUS_ERR = 1;
   localparam int ST_OVERRUN = 2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } bus_state_e;

   function automatic logic is_access(op_e op);
      return (op == OP_READ) || (op == OP_WRITE);
   endfunction

endpackage

// File: rtl/jtag_dbg_dr_if.sv
// Single-beat req/ack bus between the debug DR (master) and the system bus (slave).
interface jtag_dbg_dr_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              REQ;
   logic              WE;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;
   logic              ACK;
   logic              ERR;
   logic [DATA_W-1:0] RDATA;

   modport master (output REQ, WE, ADDR, WDATA, input ACK, ERR, RDATA);
   modport slave  (input REQ, WE, ADDR, WDATA, output ACK, ERR, RDATA);
endinterface

// File: rtl/jtag_dbg_bus_master.sv
// REQ/ACK handshake FSM with address auto-increment for the JTAG debug DR.
// Build option: JTAG_DBG_TIMEOUT_EN adds an ACK timeout counter.
module jtag_dbg_bus_master
   import jtag_dbg_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ADDR_STEP   = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              TCK,
   input  logic              RESET,
   input  logic              start,
   input  logic              start_we,
   input  logic              start_inc,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [DATA_W-1:0] start_wdata,
   input  logic              ack,
   input  logic              err,
   output logic              busy,
   output logic              req,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              rd_done,
   output logic              err_done
);

   bus_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic              inc_q, inc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef JTAG_DBG_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
`endif

   // Completion (ACK or timeout) always returns to IDLE; increment applies even on ERR.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      inc_d   = inc_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef JTAG_DBG_TIMEOUT_EN
      cnt_d   = cnt_q;
      timeout = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REQ;
               we_d    = start_we;
               inc_d   = start_inc;
               addr_d  = start_addr;
               wdata_d = start_wdata;
`ifdef JTAG_DBG_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_REQ: begin
            if (ack) begin
               state_d = S_IDLE;
               if (inc_q) addr_d = addr_q + ADDR_W'(ADDR_STEP);
            end
`ifdef JTAG_DBG_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d = S_IDLE;
               timeout = 1'b1;
            end
            else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
      endcase
      req_d = (state_d == S_REQ);
   end

   always_ff @(posedge TCK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         inc_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef JTAG_DBG_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         inc_q   <= inc_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef JTAG_DBG_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign req     = req_q;
   assign we      = we_q;
   assign addr    = addr_q;
   assign wdata   = wdata_q;
   assign rd_done = busy & ack & ~we_q;
`ifdef JTAG_DBG_TIMEOUT_EN
   assign err_done = (busy & ack & err) | timeout;
`else
   assign err_done = busy & ack & err;
`endif

endmodule

// File: rtl/jtag_dbg_dr.sv
// JTAG user DR that turns shifted {DATA, ADDR, INC, OP} commands into single bus accesses.
// Build option: JTAG_DBG_TIMEOUT_EN enables the ACK timeout in the bus master.
module jtag_dbg_dr
   import jtag_dbg_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ADDR_STEP   = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic           TCK,
   input  logic           RESET,
   input  logic           SEL,
   input  logic           CAPTURE,
   input  logic           SHIFT,
   input  logic           UPDATE,
   input  logic           TDI,
   output logic           TDO,
   jtag_dbg_dr_if.master  bus
);

   localparam int W = 3 + ADDR_W + DATA_W;

   logic [W-1:0]      sr_q, sr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              bus_err_q, bus_err_d;
   logic              overrun_q, overrun_d;

   logic              do_cap, do_shift, do_upd, start;
   op_e               upd_op;
   logic [2:0]        status;
   logic              busy, req, we, rd_done, err_done;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;

   // Only one strobe acts per cycle: CAPTURE beats SHIFT beats UPDATE.
   assign do_cap   = SEL & CAPTURE;
   assign do_shift = SEL & SHIFT & ~CAPTURE;
   assign do_upd   = SEL & UPDATE & ~CAPTURE & ~SHIFT;
   assign upd_op   = op_e'(sr_q[1:0]);
   assign start    = do_upd & ~busy & is_access(upd_op);

   always_comb begin
      status             = '0;
      status[ST_BUSY]    = busy;
      status[ST_BUS_ERR] = bus_err_q;
      status[ST_OVERRUN] = overrun_q;
   end

   always_comb begin
      sr_d      = sr_q;
      rdata_d   = rdata_q;
      bus_err_d = bus_err_q;
      overrun_d = overrun_q;
      if (do_cap)        sr_d = {rdata_q, addr, status};
      else if (do_shift) sr_d = {TDI, sr_q[W-1:1]};
      if (rd_done)  rdata_d   = bus.RDATA;
      if (err_done) bus_err_d = 1'b1;
      // Any command landing while an access is outstanding, CLEAR included, is dropped.
      if (do_upd) begin
         if (busy) begin
            overrun_d = 1'b1;
         end else if (upd_op == OP_CLEAR) begin
            bus_err_d = 1'b0;
            overrun_d = 1'b0;
         end
      end
   end

   always_ff @(posedge TCK) begin
      if (RESET) begin
         sr_q      <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
         overrun_q <= overrun_d;
      end
   end

   jtag_dbg_bus_master #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .ADDR_STEP   (ADDR_STEP),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_bus_master (
      .TCK         (TCK),
      .RESET       (RESET),
      .start       (start),
      .start_we    (upd_op == OP_WRITE),
      .start_inc   (sr_q[2]),
      .start_addr  (sr_q[3 +: ADDR_W]),
      .start_wdata (sr_q[3+ADDR_W +: DATA_W]),
      .ack         (bus.ACK),
      .err         (bus.ERR),
      .busy        (busy),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .rd_done     (rd_done),
      .err_done    (err_done)
   );

   assign TDO       = sr_q[0];
   assign bus.REQ   = req;
   assign bus.WE    = we;
   assign bus.ADDR  = addr;
   assign bus.WDATA = wdata;

endmodule
